// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory port, redirect inputs from D and the IF/ID triple.
// The master modport is the fetch stage; slave is the surrounding pipeline/memory.
interface fetch_stage_if;
  logic        f_stall;
  logic [1:0]  npc_sel;
  logic        br_taken;
  logic [31:0] d_pc;
  logic [15:0] d_imm16;
  logic [25:0] d_instr_index;
  logic [31:0] d_rs_val;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic [31:0] pcadd4_o;
  logic        addr_err;
  logic [31:0] fetch_cnt;

  modport master (
    input  f_stall, npc_sel, br_taken, d_pc, d_imm16, d_instr_index, d_rs_val, imem_rdata,
    output imem_addr, pc_o, instr_o, pcadd4_o, addr_err, fetch_cnt
  );

  modport slave (
    output f_stall, npc_sel, br_taken, d_pc, d_imm16, d_instr_index, d_rs_val, imem_rdata,
    input  imem_addr, pc_o, instr_o, pcadd4_o, addr_err, fetch_cnt
  );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC select with one delay slot,
// out-of-range fetch squashing to nop, sticky address error and fetch counter.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 4096
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus
);

  // One bit wider so the end-of-memory bound cannot wrap near the top of the address space.
  localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + (33'(IM_WORDS) * 33'd4);

  logic [31:0] pc_reg, pc_next;
  logic [31:0] fetch_cnt_reg, fetch_cnt_next;
  logic        addr_err_reg, addr_err_next;

  logic        pc_bad;
  logic [31:0] pc_seq;
  logic [31:0] d_pc_seq;
  logic [31:0] br_offset;
  logic [31:0] br_target;
  logic [31:0] j_target;

  assign pc_seq    = pc_reg + 32'd4;
  assign d_pc_seq  = bus.d_pc + 32'd4;
  assign br_offset = {{14{bus.d_imm16[15]}}, bus.d_imm16, 2'b00};
  assign br_target = d_pc_seq + br_offset;
  assign j_target  = {d_pc_seq[31:28], bus.d_instr_index, 2'b00};

  assign pc_bad = (pc_reg[1:0] != 2'b00) || (pc_reg < IM_BASE) || ({1'b0, pc_reg} >= IM_LIMIT);

  assign bus.imem_addr = pc_reg;
  assign bus.pc_o      = pc_reg;
  assign bus.pcadd4_o  = pc_seq;
  assign bus.instr_o   = pc_bad ? 32'h0 : bus.imem_rdata;
  assign bus.addr_err  = addr_err_reg;
  assign bus.fetch_cnt = fetch_cnt_reg;

  // A stall drops any redirect: D is frozen too and will present it again.
  always_comb begin
    pc_next        = pc_reg;
    fetch_cnt_next = fetch_cnt_reg;
    addr_err_next  = addr_err_reg | pc_bad;
    if (!bus.f_stall) begin
      fetch_cnt_next = fetch_cnt_reg + 32'd1;
      case (bus.npc_sel)
        2'd1:    pc_next = bus.br_taken ? br_target : pc_seq;
        2'd2:    pc_next = j_target;
        2'd3:    pc_next = bus.d_rs_val;
        default: pc_next = pc_seq;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_reg        <= RESET_PC;
      fetch_cnt_reg <= 32'd0;
      addr_err_reg  <= 1'b0;
    end else begin
      pc_reg        <= pc_next;
      fetch_cnt_reg <= fetch_cnt_next;
      addr_err_reg  <= addr_err_next;
    end
  end

endmodule
